ntt_core_gf64_red_mlane: RTL and testbench
==========================================

NTT_CORE_GF64_RED_MLANE -- requirements
Module: ntt_core_gf64_red_mlane

Interface
REQ-001 Parameter MOD_NTT_W, default 64, SHALL set the modulus width; even values only, fatal elaboration error otherwise.
REQ-002 Parameter OP_W, default 2*MOD_NTT_W+1, SHALL set the unsigned input width; MOD_NTT_W < OP_W <= 5*MOD_NTT_W/2, fatal elaboration error otherwise.
REQ-003 Parameter LANE_NB, default 4, SHALL set the number of lanes sharing one handshake.
REQ-004 Parameter SIDE_W, default 0, SHALL set the side-data width carried alongside each transaction; 0 means unused.
REQ-005 Parameter OUT_DEPTH, default 4, SHALL set the output buffer depth; OUT_DEPTH >= 3, fatal elaboration error otherwise.
REQ-006 clk  in  1  sole clock; all logic on the rising edge.
REQ-007 s_rst_n  in  1  synchronous active-low reset.
REQ-008 in_vld  in  1  input transaction valid.
REQ-009 in_rdy  out  1  block can accept an input transaction.
REQ-010 in_mode  in  1  0 = partial reduction, 1 = canonical reduction.
REQ-011 in_a  in  LANE_NB*OP_W  unsigned operands, lane i at bits [i*OP_W +: OP_W].
REQ-012 in_side  in  SIDE_W  side data.
REQ-013 out_vld  out  1  output transaction valid.
REQ-014 out_rdy  in  1  downstream accepts output.
REQ-015 out_z  out  LANE_NB*(MOD_NTT_W+2)  results, lane i at bits [i*(MOD_NTT_W+2) +: MOD_NTT_W+2].
REQ-016 out_mode, out_side  out  1, SIDE_W  in_mode and in_side of the transaction, delivered with its result.

Function
REQ-017 Input transfer SHALL occur when in_vld && in_rdy; output transfer SHALL occur when out_vld && out_rdy.
REQ-018 Pipeline: s0 registers operands, s1 registers the partial result, s2 registers the final result; s2 writes into an OUT_DEPTH-entry FIFO. Stages SHALL never stall; every stage advances each cycle.
REQ-019 Credit rule: in_rdy SHALL be 1 iff (transactions in s0..s2 + FIFO occupancy) < OUT_DEPTH, evaluated from registered state only. in_rdy SHALL NOT depend combinationally on out_rdy or in_vld.
REQ-020 Latency: a transaction accepted at cycle t with an empty FIFO SHALL give out_vld=1 at cycle t+3 (FIFO is fall-through).
REQ-021 Transactions SHALL leave in acceptance order, with mode and side data kept aligned.
REQ-022 Partial reduction, per lane: split the zero-extended operand into MID_W=MOD_NTT_W/2 chunks a0..a4. Compute z = {a1,a0} - a2 + (a2<<MID_W) - {a4,a3} modulo 2^(MOD_NTT_W+2), as a two's-complement value.
REQ-023 Canonical reduction, per lane (mode 1): s2 SHALL output the unique value in [0,p) congruent to z, with p = 2^MOD_NTT_W - 2^MID_W + 1. The value is zero-extended to MOD_NTT_W+2 bits, using conditional additions/subtractions of p and 2p over the range -2p < z < 3p.
REQ-024 In mode 0, s2 SHALL pass z through unchanged.
REQ-025 Simultaneous input and output transfer with a full credit count SHALL keep the count unchanged. in_rdy SHALL rise the cycle after the credit frees.
REQ-026 Output holds: while out_vld && !out_rdy, out_z, out_mode and out_side SHALL remain stable.
REQ-027 FIFO overflow SHALL be impossible under REQ-019. An assertion SHALL flag a write to a full FIFO.

Reset
REQ-028 While s_rst_n=0, on the clock edge the block SHALL clear all stage valids, the credit count and the FIFO pointers.
REQ-029 During and immediately after reset, in_rdy SHALL be 0, then 1 from the first cycle after s_rst_n rises. out_vld SHALL be 0.
REQ-030 out_z, out_side and out_mode SHALL be 0 after reset. Datapath registers need not be reset.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight and buffered transactions. No output SHALL appear for them.

Verification
REQ-032 MOD_NTT_W=64, mode 1, in_a lane0 = 2^64 -> out_z lane0 = 0x0_FFFFFFFF.
REQ-033 Mode 1, in_a = p = 0xFFFFFFFF00000001 -> 0. Mode 0, same input -> 0xFFFFFFFF00000001.
REQ-034 in_a = 2^96: mode 0 -> all-ones 66-bit (-1); mode 1 -> 0xFFFFFFFF00000000.
REQ-035 Hold out_rdy=0 and drive in_vld=1 continuously -> exactly OUT_DEPTH transfers, then in_rdy=0. Raise out_rdy -> results appear in order, with side data matching, and no loss or duplication.
REQ-036 Random LANE_NB=4 traffic, random out_rdy, mixed modes -> every lane matches a reference model computing a mod p (mode 1) and REQ-022 (mode 0).
REQ-037 Reset pulsed with 3 transactions in flight -> out_vld=0 until new input; first new result arrives 3 cycles after its acceptance.

Source files
------------

// File: rtl/ntt_core_gf64_red_mlane.sv
// ntt_core_gf64_red_mlane
//   Multi-lane reduction modulo the Goldilocks-style prime
//   p = 2^MOD_NTT_W - 2^(MOD_NTT_W/2) + 1 for NTT datapaths.
//   Three-stage non-stalling pipeline (s0 operands, s1 partial result,
//   s2 final result) feeding a fall-through output FIFO. A credit counter
//   guarantees the FIFO can always absorb everything in flight.
//
// Ports
//   clk       sole clock, rising edge
//   s_rst_n   synchronous active-low reset
//   in_vld    input transaction valid
//   in_rdy    input can be accepted (registered, credit based)
//   in_mode   0 = partial reduction, 1 = canonical reduction
//   in_a      LANE_NB unsigned operands, OP_W bits each
//   in_side   side data carried with the transaction
//   out_vld   output transaction valid
//   out_rdy   downstream accepts output
//   out_z     LANE_NB results, MOD_NTT_W+2 bits each
//   out_mode  mode of the delivered transaction
//   out_side  side data of the delivered transaction

module ntt_core_gf64_red_mlane_chk #(
  parameter int OUT_DEPTH = 4,
  parameter int CNT_W     = 3
) (
  input logic             clk,
  input logic             s_rst_n,
  input logic             fifo_wr,
  input logic [CNT_W-1:0] fifo_cnt
);
  // A write while the FIFO already holds OUT_DEPTH entries would lose data
  a_no_fifo_overflow: assert property (@(posedge clk) disable iff (!s_rst_n)
    !(fifo_wr && (fifo_cnt == CNT_W'(OUT_DEPTH))))
    else $error("write to full output FIFO");
endmodule

module ntt_core_gf64_red_mlane #(
  parameter int MOD_NTT_W = 64,
  parameter int OP_W      = 2*MOD_NTT_W+1,
  parameter int LANE_NB   = 4,
  parameter int SIDE_W    = 0,
  parameter int OUT_DEPTH = 4
) (
  input  logic                                    clk,
  input  logic                                    s_rst_n,
  input  logic                                    in_vld,
  output logic                                    in_rdy,
  input  logic                                    in_mode,
  input  logic [LANE_NB*OP_W-1:0]                 in_a,
  input  logic [((SIDE_W > 0) ? SIDE_W : 1)-1:0]  in_side,
  output logic                                    out_vld,
  input  logic                                    out_rdy,
  output logic [LANE_NB*(MOD_NTT_W+2)-1:0]        out_z,
  output logic                                    out_mode,
  output logic [((SIDE_W > 0) ? SIDE_W : 1)-1:0]  out_side
);
  localparam int MID_W = MOD_NTT_W/2;
  localparam int Z_W   = MOD_NTT_W+2;
  localparam int X_W   = 5*MID_W;        // operand zero-extended to five chunks
  localparam int E_W   = MOD_NTT_W+4;    // signed work width for canonical fixup
  localparam int SW    = (SIDE_W > 0) ? SIDE_W : 1;
  localparam int A_ALL = LANE_NB*OP_W;
  localparam int Z_ALL = LANE_NB*Z_W;
  localparam int FW    = 1+SW+Z_ALL;     // FIFO entry {mode, side, z}
  localparam int CNT_W = $clog2(OUT_DEPTH+1);
  localparam int PTR_W = $clog2(OUT_DEPTH);
  localparam logic [E_W-1:0] ONE_E = E_W'(1'b1);
  localparam logic [E_W-1:0] MOD_P = (ONE_E << MOD_NTT_W) - (ONE_E << MID_W) + ONE_E;

  if ((MOD_NTT_W % 2) != 0) begin : g_bad_mod_w
    $fatal(1, "MOD_NTT_W must be even");
  end
  if (!((OP_W > MOD_NTT_W) && (OP_W <= (5*MOD_NTT_W)/2))) begin : g_bad_op_w
    $fatal(1, "OP_W out of range");
  end
  if (OUT_DEPTH < 3) begin : g_bad_depth
    $fatal(1, "OUT_DEPTH must be at least 3");
  end

  // Folds 2^(2*MID_W) == 2^MID_W - 1 and 2^(3*MID_W) == -1 (mod p)
  function automatic logic [Z_W-1:0] part_red(input logic [OP_W-1:0] a);
    logic [X_W-1:0] x;
    logic [Z_W-1:0] lo, a2, hi;
    x  = X_W'(a);
    lo = Z_W'(x[2*MID_W-1:0]);
    a2 = Z_W'(x[3*MID_W-1:2*MID_W]);
    hi = Z_W'(x[5*MID_W-1:3*MID_W]);
    return lo - a2 + (a2 << MID_W) - hi;
  endfunction

  // Brings a two's-complement z in (-2p, 3p) into [0, p)
  function automatic logic [Z_W-1:0] canon_red(input logic [Z_W-1:0] z);
    logic signed [E_W-1:0] zs, p1, p2, t, r;
    zs = {{2{z[Z_W-1]}}, z};
    p1 = MOD_P;
    p2 = MOD_P << 1;
    t  = zs + p1;
    if (zs[E_W-1]) begin
      r = t[E_W-1] ? (zs + p2) : t;
    end else if (zs < p1) begin
      r = zs;
    end else if (zs < p2) begin
      r = zs - p1;
    end else begin
      r = zs - p2;
    end
    return r[Z_W-1:0];
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH-1)) ? '0 : p + PTR_W'(1'b1);
  endfunction

  logic              s0_vld_r, s1_vld_r, s2_vld_r;
  logic              s0_mode_r, s1_mode_r, s2_mode_r;
  logic [SW-1:0]     s0_side_r, s1_side_r, s2_side_r;
  logic [A_ALL-1:0]  s0_a_r;
  logic [Z_ALL-1:0]  s1_z_r, s2_z_r, s1_z_s, s2_z_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s, fcnt_r, fcnt_nxt_s;
  logic              in_rdy_r, in_xfer_s, out_xfer_s, out_vld_s;
  logic              fifo_empty_s, fifo_wr_s, fifo_rd_s;
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
  logic [FW-1:0]     mem_r [OUT_DEPTH];
  logic [FW-1:0]     s2_ent_s, head_s;

  assign in_xfer_s    = in_vld && in_rdy_r;
  assign fifo_empty_s = (fcnt_r == '0);
  assign out_vld_s    = s2_vld_r || !fifo_empty_s;
  assign out_xfer_s   = out_vld_s && out_rdy;
  // s2 bypasses the FIFO only when it is empty and the result leaves at once
  assign fifo_wr_s    = s2_vld_r && !(fifo_empty_s && out_rdy);
  assign fifo_rd_s    = !fifo_empty_s && out_rdy;
  assign s2_ent_s     = {s2_mode_r, s2_side_r, s2_z_r};

  // Partial reduction of every lane from the s0 operands
  always_comb begin
    s1_z_s = '0;
    for (int i = 0; i < LANE_NB; i++) begin
      s1_z_s[i*Z_W +: Z_W] = part_red(s0_a_r[i*OP_W +: OP_W]);
    end
  end

  // Optional canonical fixup of every lane from the s1 partial results
  always_comb begin
    s2_z_s = '0;
    for (int i = 0; i < LANE_NB; i++) begin
      if (s1_mode_r) begin
        s2_z_s[i*Z_W +: Z_W] = canon_red(s1_z_r[i*Z_W +: Z_W]);
      end else begin
        s2_z_s[i*Z_W +: Z_W] = s1_z_r[i*Z_W +: Z_W];
      end
    end
  end

  // Credit count: everything in s0..s2 plus FIFO contents
  always_comb begin
    cnt_nxt_s = cnt_r;
    case ({in_xfer_s, out_xfer_s})
      2'b10:   cnt_nxt_s = cnt_r + CNT_W'(1'b1);
      2'b01:   cnt_nxt_s = cnt_r - CNT_W'(1'b1);
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // FIFO occupancy next value
  always_comb begin
    fcnt_nxt_s = fcnt_r;
    case ({fifo_wr_s, fifo_rd_s})
      2'b10:   fcnt_nxt_s = fcnt_r + CNT_W'(1'b1);
      2'b01:   fcnt_nxt_s = fcnt_r - CNT_W'(1'b1);
      default: fcnt_nxt_s = fcnt_r;
    endcase
  end

  // Output head: FIFO front when non-empty, otherwise s2 falls through
  always_comb begin
    head_s = s2_ent_s;
    if (!fifo_empty_s) begin
      head_s = mem_r[rd_ptr_r];
    end else begin
      head_s = s2_ent_s;
    end
  end

  // Control state: stage valids, credit count, registered in_rdy
  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      s0_vld_r <= 1'b0;
      s1_vld_r <= 1'b0;
      s2_vld_r <= 1'b0;
      cnt_r    <= '0;
      in_rdy_r <= 1'b0;
    end else begin
      s0_vld_r <= in_xfer_s;
      s1_vld_r <= s0_vld_r;
      s2_vld_r <= s1_vld_r;
      cnt_r    <= cnt_nxt_s;
      in_rdy_r <= (cnt_nxt_s < CNT_W'(OUT_DEPTH));
    end
  end

  // Datapath stage registers, qualified by the valids above
  always_ff @(posedge clk) begin
    s0_a_r    <= in_a;
    s0_mode_r <= in_mode;
    s0_side_r <= in_side;
    s1_z_r    <= s1_z_s;
    s1_mode_r <= s0_mode_r;
    s1_side_r <= s0_side_r;
    s2_z_r    <= s2_z_s;
    s2_mode_r <= s1_mode_r;
    s2_side_r <= s1_side_r;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      fcnt_r   <= '0;
    end else begin
      if (fifo_wr_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (fifo_rd_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
      fcnt_r <= fcnt_nxt_s;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (fifo_wr_s) mem_r[wr_ptr_r] <= s2_ent_s;
  end

  assign in_rdy   = in_rdy_r;
  assign out_vld  = out_vld_s;
  assign out_z    = out_vld_s ? head_s[Z_ALL-1:0] : '0;
  assign out_side = out_vld_s ? head_s[Z_ALL +: SW] : '0;
  assign out_mode = out_vld_s && head_s[FW-1];

  ntt_core_gf64_red_mlane_chk #(
    .OUT_DEPTH (OUT_DEPTH),
    .CNT_W     (CNT_W)
  ) u_chk (
    .clk      (clk),
    .s_rst_n  (s_rst_n),
    .fifo_wr  (fifo_wr_s),
    .fifo_cnt (fcnt_r)
  );
endmodule

// File: tb/tb_ntt_core_gf64_red_mlane.sv
// Self-checking bench for ntt_core_gf64_red_mlane: table of hand-computed
// reduction vectors, scoreboard on the output handshake, and directed
// sequences for reset, latency, back-pressure and mid-flight reset.
module tb_ntt_core_gf64_red_mlane;
  localparam int MW = 64;
  localparam int OW = 129;
  localparam int LN = 4;
  localparam int SW = 8;
  localparam int OD = 4;
  localparam int ZW = MW+2;
  localparam int NV = 8;
  localparam logic [63:0] P64 = 64'hFFFFFFFF_00000001;

  logic clk = 1'b0;
  logic s_rst_n, in_vld, in_rdy, in_mode, out_vld, out_rdy, out_mode;
  logic [LN*OW-1:0] in_a;
  logic [SW-1:0] in_side, out_side;
  logic [LN*ZW-1:0] out_z;

  typedef struct { logic [OW-1:0] a; logic [ZW-1:0] z0; logic [ZW-1:0] z1; } vec_t;
  typedef struct { logic [LN*ZW-1:0] z; logic mode; logic [SW-1:0] side; } exp_t;

  vec_t tbl [NV];
  exp_t sbq [$];
  exp_t cur_exp, mon_e;
  int total = 0, bad = 0;
  logic rnd_en = 1'b0;
  logic stall_prev = 1'b0;
  logic [LN*ZW+SW:0] hold_v;

  ntt_core_gf64_red_mlane #(
    .MOD_NTT_W (MW), .OP_W (OW), .LANE_NB (LN), .SIDE_W (SW), .OUT_DEPTH (OD)
  ) dut (
    .clk (clk), .s_rst_n (s_rst_n), .in_vld (in_vld), .in_rdy (in_rdy),
    .in_mode (in_mode), .in_a (in_a), .in_side (in_side), .out_vld (out_vld),
    .out_rdy (out_rdy), .out_z (out_z), .out_mode (out_mode), .out_side (out_side)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [LN*ZW+SW:0] got, input logic [LN*ZW+SW:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  function automatic logic [ZW-1:0] ref_mod(input logic [OW-1:0] a);
    logic [OW-1:0] q;
    q = a % OW'(P64);
    return q[ZW-1:0];
  endfunction

  function automatic logic [ZW-1:0] ref_part(input logic [OW-1:0] a);
    logic [159:0] x;
    logic [ZW-1:0] lo, a2, hi;
    x  = 160'(a);
    lo = ZW'(x[63:0]);
    a2 = ZW'(x[95:64]);
    hi = ZW'(x[159:96]);
    return lo + (a2 << 32) - a2 - hi;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_en) out_rdy = ($urandom_range(3, 0) != 0);
  endtask

  // Lane i takes table row (k+i) mod NV so every lane sees every vector
  task automatic build(input int k, input int m, output logic [LN*OW-1:0] a, output logic [LN*ZW-1:0] ez);
    for (int i = 0; i < LN; i++) begin
      a[i*OW +: OW]  = tbl[(k+i)%NV].a;
      ez[i*ZW +: ZW] = (m != 0) ? tbl[(k+i)%NV].z1 : tbl[(k+i)%NV].z0;
    end
  endtask

  task automatic send(input logic m, input logic [SW-1:0] sd, input logic [LN*OW-1:0] a, input logic [LN*ZW-1:0] ez);
    logic acc;
    int n;
    in_vld = 1'b1; in_mode = m; in_side = sd; in_a = a;
    cur_exp.z = ez; cur_exp.mode = m; cur_exp.side = sd;
    acc = 1'b0; n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_rdy;
      tick();
      n++;
    end
    in_vld = 1'b0;
    total++;
    if (!acc) begin
      bad++;
      $display("FAIL send_timeout: got no in_rdy want in_rdy within 200 cycles");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    chk("drain_left", sbq.size(), 0);
    tick(); tick();
    chk("idle_out_vld", out_vld, 1'b0);
  endtask

  task automatic lat_check(input int k, input int m, input logic [SW-1:0] sd);
    logic [LN*OW-1:0] a;
    logic [LN*ZW-1:0] ez;
    int n;
    build(k, m, a, ez);
    send(1'(m), sd, a, ez);
    n = 1;
    while (!out_vld && n < 10) begin
      tick();
      n++;
    end
    chk("latency", n, 3);
  endtask

  // Scoreboard and output-hold monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (s_rst_n === 1'b1) begin
      if (stall_prev) chk("hold", {out_mode, out_side, out_z}, hold_v);
      if (in_vld && in_rdy) sbq.push_back(cur_exp);
      if (out_vld && out_rdy) begin
        if (sbq.size() == 0) begin
          chk("unexpected_out", 1'b1, 1'b0);
        end else begin
          mon_e = sbq.pop_front();
          for (int i = 0; i < LN; i++)
            chk($sformatf("lane%0d", i), out_z[i*ZW +: ZW], mon_e.z[i*ZW +: ZW]);
          chk("mode_side", {out_mode, out_side}, {mon_e.mode, mon_e.side});
        end
      end
      stall_prev = out_vld && !out_rdy;
      hold_v = {out_mode, out_side, out_z};
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish want finish before 40000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LN*OW-1:0] a;
    logic [LN*ZW-1:0] ez;
    logic [OW-1:0] op;
    int acc, m;

    tbl[0] = '{a: 129'h0, z0: 66'h0, z1: 66'h0};
    tbl[1] = '{a: 129'h1_00000000_00000000, z0: 66'h0_00000000_FFFFFFFF, z1: 66'h0_00000000_FFFFFFFF};
    tbl[2] = '{a: 129'hFFFFFFFF_00000001, z0: 66'h0_FFFFFFFF_00000001, z1: 66'h0};
    tbl[3] = '{a: 129'h1_00000000_00000000_00000000, z0: 66'h3_FFFFFFFF_FFFFFFFF, z1: 66'h0_FFFFFFFF_00000000};
    tbl[4] = '{a: 129'h1_00000000_00000000_00000000_00000000, z0: 66'h3_FFFFFFFF_00000000, z1: 66'h0_FFFFFFFE_00000001};
    tbl[5] = '{a: 129'h1_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, z0: 66'h1_FFFFFFFC_00000001, z1: 66'h0_FFFFFFFD_00000000};
    tbl[6] = '{a: 129'h1_00000000_00000000_00000000_00000005, z0: 66'h3_FFFFFFFF_00000005, z1: 66'h0_FFFFFFFE_00000006};
    tbl[7] = '{a: 129'hFFFFFFFF_00000006, z0: 66'h0_FFFFFFFF_00000006, z1: 66'h5};

    s_rst_n = 1'b0; in_vld = 1'b0; in_mode = 1'b0; in_a = '0; in_side = '0; out_rdy = 1'b1;
    cur_exp.z = '0; cur_exp.mode = 1'b0; cur_exp.side = '0;

    // Reset state
    tick(); tick(); tick();
    chk("rst_in_rdy", in_rdy, 1'b0);
    chk("rst_out_vld", out_vld, 1'b0);
    chk("rst_out_z", out_z, '0);
    chk("rst_out_mode", out_mode, 1'b0);
    chk("rst_out_side", out_side, '0);
    s_rst_n = 1'b1;
    chk("post_rst_in_rdy_low", in_rdy, 1'b0);
    tick();
    chk("post_rst_in_rdy_high", in_rdy, 1'b1);

    // First-result latency from an empty pipeline
    lat_check(1, 1, 8'hA5);
    drain();

    // Table vectors in both modes, streamed back to back
    for (int k = 0; k < NV; k++) begin
      for (int mm = 0; mm < 2; mm++) begin
        build(k, mm, a, ez);
        send(1'(mm), 8'(k*2+mm), a, ez);
      end
    end
    drain();

    // Back-pressure: exactly OUT_DEPTH accepts, then credit reopens
    out_rdy = 1'b0;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      build(acc, acc % 2, a, ez);
      in_vld = 1'b1; in_mode = 1'(acc % 2); in_side = 8'(8'h40 + acc); in_a = a;
      cur_exp.z = ez; cur_exp.mode = 1'(acc % 2); cur_exp.side = 8'(8'h40 + acc);
      @(negedge clk);
      if (in_rdy) acc++;
      tick();
    end
    in_vld = 1'b0;
    chk("bp_accepts", acc, OD);
    chk("bp_in_rdy_low", in_rdy, 1'b0);
    chk("bp_out_vld", out_vld, 1'b1);
    out_rdy = 1'b1;
    tick();
    chk("bp_in_rdy_reopen", in_rdy, 1'b1);
    drain();

    // Reset with three transactions in flight
    for (int k = 0; k < 3; k++) begin
      build(k+2, 1, a, ez);
      send(1'b1, 8'(8'h80 + k), a, ez);
    end
    s_rst_n = 1'b0;
    sbq.delete();
    tick();
    s_rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("flush_out_vld", out_vld, 1'b0);
    end
    lat_check(3, 0, 8'hC3);
    drain();

    // Random traffic against a mod-p reference with random back-pressure
    rnd_en = 1'b1;
    for (int t = 0; t < 40; t++) begin
      m = int'($urandom_range(1, 0));
      for (int i = 0; i < LN; i++) begin
        op = {1'($urandom_range(1, 0)), $urandom(), $urandom(), $urandom(), $urandom()};
        a[i*OW +: OW]  = op;
        ez[i*ZW +: ZW] = (m != 0) ? ref_mod(op) : ref_part(op);
      end
      send(1'(m), 8'($urandom_range(255, 0)), a, ez);
    end
    rnd_en = 1'b0;
    out_rdy = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
